// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 hex keypad path.
//   state_t        controller states
//   onehot_idx_t   result of onehot_to_idx (valid flag + 2-bit bit position)
//   KEY_MAP        hex code per key, indexed by {row, col} bit positions
//                  (bit 3 = top row / leftmost column)
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } onehot_idx_t;

  // Entry {r,c}. Physical layout, top row first, left to right:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [3:0] KEY_MAP [16] = '{
    4'hD, 4'hF, 4'h0, 4'hE,   // r0: c0..c3
    4'hC, 4'h9, 4'h8, 4'h7,   // r1
    4'hB, 4'h6, 4'h5, 4'h4,   // r2
    4'hA, 4'h3, 4'h2, 4'h1    // r3
  };

  function automatic onehot_idx_t onehot_to_idx(input logic [3:0] vec);
    onehot_idx_t res;
    res = '0;
    case (vec)
      4'b0001: res = '{valid: 1'b1, idx: 2'd0};
      4'b0010: res = '{valid: 1'b1, idx: 2'd1};
      4'b0100: res = '{valid: 1'b1, idx: 2'd2};
      4'b1000: res = '{valid: 1'b1, idx: 2'd3};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_decoder.sv
// keypad_decoder: combinational decode of one scanner sample.
//   rowsSync  in   row sense for the currently driven column
//   colsSync  in   column drive, must be one-hot to count as a visit
//   visit     out  colsSync is exactly one-hot
//   c         out  driven column bit position
//   r         out  highest closed row bit position (0 when none)
//   anyRow    out  at least one row closed
//   code      out  hex code of key (r, c)
module keypad_decoder
  import keypad_pkg::*;
(
  input  logic [3:0] rowsSync,
  input  logic [3:0] colsSync,
  output logic       visit,
  output logic [1:0] c,
  output logic [1:0] r,
  output logic       anyRow,
  output logic [3:0] code
);

  onehot_idx_t col;

  always_comb begin
    col    = onehot_to_idx(colsSync);
    visit  = col.valid;
    c      = col.idx;
    anyRow = |rowsSync;
    // Highest row wins when several are closed.
    casez (rowsSync)
      4'b1???: r = 2'd3;
      4'b01??: r = 2'd2;
      4'b001?: r = 2'd1;
      default: r = 2'd0;
    endcase
    code = KEY_MAP[{r, c}];
  end

endmodule

// File: rtl/keypad_controller.sv
// keypad_controller: debounce, decode and one-key lockout for a 4x4 keypad.
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   rowsSync  in   synchronized rows (high = key closed in driven column)
//   colsSync  in   synchronized one-hot column drive
//   key       out  hex code of last accepted key
//   keyValid  out  one-cycle strobe per accepted press
//   keyHeld   out  accepted key not yet released
//   digitOld  out  previous accepted key
//   digitNew  out  most recent accepted key
module keypad_controller
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_ROUNDS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rowsSync,
  input  logic [3:0] colsSync,
  output logic [3:0] key,
  output logic       keyValid,
  output logic       keyHeld,
  output logic [3:0] digitOld,
  output logic [3:0] digitNew
);

  localparam int unsigned   CW   = $clog2(DEBOUNCE_ROUNDS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_ROUNDS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          visit;
  logic [1:0]    dec_c;
  logic [1:0]    dec_r;
  logic          any_row;
  logic [3:0]    dec_code;

  state_t        state;
  logic [CW-1:0] count;
  logic [1:0]    cand_c;
  logic [1:0]    cand_r;

  logic          cand_hit;
  logic          cand_row;
  logic          accept;
  logic [3:0]    accept_code;

  keypad_decoder u_decoder (
    .rowsSync (rowsSync),
    .colsSync (colsSync),
    .visit    (visit),
    .c        (dec_c),
    .r        (dec_r),
    .anyRow   (any_row),
    .code     (dec_code)
  );

  always_comb begin
    cand_hit    = visit && (dec_c == cand_c);
    cand_row    = rowsSync[cand_r];
    accept      = ((state == IDLE) && visit && any_row && (DEBOUNCE_ROUNDS == 1)) ||
                  ((state == DEBOUNCE) && cand_hit && cand_row && (count == LAST));
    // A single-round press is accepted straight from IDLE before the
    // candidate registers are loaded, so take the code from the decoder.
    accept_code = (state == IDLE) ? dec_code : KEY_MAP[{cand_r, cand_c}];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      cand_c   <= '0;
      cand_r   <= '0;
      key      <= '0;
      keyValid <= 1'b0;
      keyHeld  <= 1'b0;
      digitOld <= '0;
      digitNew <= '0;
    end else begin
      keyValid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (visit && any_row) begin
            cand_c <= dec_c;
            cand_r <= dec_r;
            count  <= ONE;
            state  <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (cand_hit) begin
            if (cand_row) begin
              // Acceptance happens at count == LAST, so this lands exactly
              // on DEBOUNCE_ROUNDS and never exceeds it.
              count <= count + 1'b1;
            end else begin
              count <= '0;
              state <= IDLE;
            end
          end
        end
        HELD: begin
          if (cand_hit && !cand_row) begin
            if (DEBOUNCE_ROUNDS == 1) begin
              count   <= '0;
              keyHeld <= 1'b0;
              state   <= IDLE;
            end else begin
              count <= ONE;
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cand_hit) begin
            if (cand_row) begin
              state <= HELD;
            end else if (count == LAST) begin
              count   <= '0;
              keyHeld <= 1'b0;
              state   <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Overrides the DEBOUNCE/IDLE next-state chosen above.
      if (accept) begin
        state    <= HELD;
        key      <= accept_code;
        digitOld <= digitNew;
        digitNew <= accept_code;
        keyValid <= 1'b1;
        keyHeld  <= 1'b1;
      end
    end
  end

endmodule
